// File: rtl/arith_unit_pipelined.sv
// Pipelined ADD/ADC/SUB/SBC/RSB/RSC/CMP/CMN unit with ARM NZCV flags and valid/ready on both sides.
// SPLIT=1 breaks the carry chain at WIDTH/2 across two register stages.
module arith_unit_pipelined #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned TAG_WIDTH = 4,
  parameter bit          SPLIT     = 1'b0
) (
  input  logic                 clk,
  input  logic                 nReset,
  input  logic                 flush,
  input  logic                 inValid,
  output logic                 inReady,
  input  logic [2:0]           opcode,
  input  logic [WIDTH-1:0]     firstInput,
  input  logic [WIDTH-1:0]     secondInput,
  input  logic                 carryFlag,
  input  logic [TAG_WIDTH-1:0] inTag,
  output logic                 outValid,
  input  logic                 outReady,
  output logic [WIDTH-1:0]     result,
  output logic                 writeEnable,
  output logic [3:0]           flagsOut,
  output logic [TAG_WIDTH-1:0] outTag
);

  localparam logic [2:0] OP_ADC = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_SBC = 3'd3;
  localparam logic [2:0] OP_RSB = 3'd4;
  localparam logic [2:0] OP_RSC = 3'd5;
  localparam logic [2:0] OP_CMP = 3'd6;

  logic [WIDTH-1:0]     x_c;
  logic [WIDTH-1:0]     y_c;
  logic                 cin_c;
  logic                 we_c;
  logic                 accept_c;
  logic                 out_load_c;
  logic                 s1_load_c;

  logic                 out_valid_q;
  logic [WIDTH-1:0]     result_q;
  logic [3:0]           flags_q;
  logic                 we_q;
  logic [TAG_WIDTH-1:0] tag_q;

  // Adder operand/carry-in selection; ADD and CMN take the defaults.
  always_comb begin
    x_c   = firstInput;
    y_c   = secondInput;
    cin_c = 1'b0;
    case (opcode)
      OP_ADC: cin_c = carryFlag;
      OP_SUB, OP_CMP: begin
        y_c   = ~secondInput;
        cin_c = 1'b1;
      end
      OP_SBC: begin
        y_c   = ~secondInput;
        cin_c = carryFlag;
      end
      OP_RSB: begin
        x_c   = secondInput;
        y_c   = ~firstInput;
        cin_c = 1'b1;
      end
      OP_RSC: begin
        x_c   = secondInput;
        y_c   = ~firstInput;
        cin_c = carryFlag;
      end
      default: ;
    endcase
  end

  // CMP (6) and CMN (7) only update flags.
  assign we_c       = ~(opcode[2] & opcode[1]);
  assign out_load_c = ~out_valid_q | outReady;
  assign inReady    = nReset & ~flush & s1_load_c;
  assign accept_c   = inValid & inReady;

  function automatic logic [3:0] nzcv_f(input logic [WIDTH-1:0] r, input logic c,
                                        input logic xm, input logic ym);
    nzcv_f = {r[WIDTH-1], (r == '0), c, (xm == ym) & (r[WIDTH-1] != xm)};
  endfunction

  generate
    if (SPLIT == 1'b0) begin : g_single
      logic [WIDTH:0]   sum_d;
      logic [WIDTH-1:0] res_d;
      logic [3:0]       flags_d;

      assign sum_d     = {1'b0, x_c} + {1'b0, y_c} + {{WIDTH{1'b0}}, cin_c};
      assign res_d     = sum_d[WIDTH-1:0];
      assign flags_d   = nzcv_f(res_d, sum_d[WIDTH], x_c[WIDTH-1], y_c[WIDTH-1]);
      assign s1_load_c = out_load_c;

      always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
          out_valid_q <= 1'b0;
          result_q    <= '0;
          flags_q     <= '0;
          we_q        <= 1'b0;
          tag_q       <= '0;
        end else if (flush) begin
          out_valid_q <= 1'b0;
        end else if (out_load_c) begin
          out_valid_q <= accept_c;
          if (accept_c) begin
            result_q <= res_d;
            flags_q  <= flags_d;
            we_q     <= we_c;
            tag_q    <= inTag;
          end
        end
      end
    end else begin : g_split
      localparam int unsigned HALF = WIDTH / 2;

      logic                 s1_valid_q;
      logic [HALF-1:0]      s1_lo_q;
      logic [HALF-1:0]      s1_xh_q;
      logic [HALF-1:0]      s1_yh_q;
      logic                 s1_carry_q;
      logic                 s1_we_q;
      logic [TAG_WIDTH-1:0] s1_tag_q;

      logic [HALF:0]        lo_sum_d;
      logic [HALF:0]        hi_sum_d;
      logic [WIDTH-1:0]     res_d;
      logic [3:0]           flags_d;

      assign lo_sum_d  = {1'b0, x_c[HALF-1:0]} + {1'b0, y_c[HALF-1:0]} + {{HALF{1'b0}}, cin_c};
      assign hi_sum_d  = {1'b0, s1_xh_q} + {1'b0, s1_yh_q} + {{HALF{1'b0}}, s1_carry_q};
      assign res_d     = {hi_sum_d[HALF-1:0], s1_lo_q};
      assign flags_d   = nzcv_f(res_d, hi_sum_d[HALF], s1_xh_q[HALF-1], s1_yh_q[HALF-1]);
      assign s1_load_c = ~s1_valid_q | out_load_c;

      // Stage 1: low half sum plus carry, high operands carried forward.
      always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
          s1_valid_q <= 1'b0;
          s1_lo_q    <= '0;
          s1_xh_q    <= '0;
          s1_yh_q    <= '0;
          s1_carry_q <= 1'b0;
          s1_we_q    <= 1'b0;
          s1_tag_q   <= '0;
        end else if (flush) begin
          s1_valid_q <= 1'b0;
        end else if (s1_load_c) begin
          s1_valid_q <= accept_c;
          if (accept_c) begin
            s1_lo_q    <= lo_sum_d[HALF-1:0];
            s1_carry_q <= lo_sum_d[HALF];
            s1_xh_q    <= x_c[WIDTH-1:HALF];
            s1_yh_q    <= y_c[WIDTH-1:HALF];
            s1_we_q    <= we_c;
            s1_tag_q   <= inTag;
          end
        end
      end

      // Stage 2: high half with registered carry, flags over the full result.
      always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
          out_valid_q <= 1'b0;
          result_q    <= '0;
          flags_q     <= '0;
          we_q        <= 1'b0;
          tag_q       <= '0;
        end else if (flush) begin
          out_valid_q <= 1'b0;
        end else if (out_load_c) begin
          out_valid_q <= s1_valid_q;
          if (s1_valid_q) begin
            result_q <= res_d;
            flags_q  <= flags_d;
            we_q     <= s1_we_q;
            tag_q    <= s1_tag_q;
          end
        end
      end
    end
  endgenerate

  assign outValid    = out_valid_q;
  assign result      = result_q;
  assign flagsOut    = flags_q;
  assign writeEnable = we_q;
  assign outTag      = tag_q;

endmodule
